// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port data memory.
// Port 0 is the CPU MEM stage, port 1 the debug/loader port; one grant per cycle.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [1:0]        dbg_size,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [CNT_W-1:0] starve_cnt;
    logic             dbg_locked;
    logic             starved;
    logic             dbg_win;
    logic             any_gnt;

    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_off;
    logic              req_ok;
    logic [3:0]        be_raw;
    logic [31:0]       wdata_rep;

    logic        resp_valid;
    owner_t      resp_owner;
    logic [1:0]  resp_off;
    logic [1:0]  resp_size;
    logic        resp_we;
    logic        resp_err;
    logic [31:0] rd_shift;
    logic [31:0] rd_data;

    assign starved = (starve_cnt == CNT_W'(MAX_WAIT));

    // Debug wins on lock, on starvation, or when the CPU is idle.
    assign dbg_win   = dbg_req & (dbg_locked | starved | ~cpu_req);
    assign dbg_gnt   = ~rst & dbg_win;
    assign cpu_gnt   = ~rst & cpu_req & ~dbg_win;
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign any_gnt   = cpu_gnt | dbg_gnt;

    assign sel_we    = dbg_gnt ? dbg_we    : cpu_we;
    assign sel_size  = dbg_gnt ? dbg_size  : cpu_size;
    assign sel_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    assign sel_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign sel_off   = sel_addr[1:0];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        req_ok    = 1'b0;
        be_raw    = 4'b0000;
        wdata_rep = sel_wdata;
        case (sel_size)
            SZ_BYTE: begin
                req_ok    = 1'b1;
                be_raw    = 4'b0001 << sel_off;
                wdata_rep = {4{sel_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_ok    = ~sel_off[0];
                be_raw    = 4'b0011 << sel_off;
                wdata_rep = {2{sel_wdata[15:0]}};
            end
            SZ_WORD: begin
                req_ok    = (sel_off == 2'b00);
                be_raw    = 4'b1111;
            end
            default: req_ok = 1'b0;
        endcase
    end

    // Invalid requests are consumed by the grant but never reach the memory.
    assign mem_en    = any_gnt & req_ok;
    assign mem_we    = mem_en & sel_we;
    assign mem_be    = mem_en ? be_raw : 4'b0000;
    assign mem_addr  = mem_en ? {sel_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = mem_en ? wdata_rep : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            dbg_locked <= 1'b0;
            resp_valid <= 1'b0;
            resp_owner <= OWN_CPU;
            resp_off   <= 2'b00;
            resp_size  <= 2'b00;
            resp_we    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            if (dbg_gnt)
                starve_cnt <= '0;
            else if (dbg_req && !starved)
                starve_cnt <= starve_cnt + CNT_W'(1);

            if (dbg_gnt && dbg_lock)
                dbg_locked <= 1'b1;
            else if (!dbg_req || !dbg_lock)
                dbg_locked <= 1'b0;

            resp_valid <= any_gnt;
            resp_owner <= dbg_gnt ? OWN_DBG : OWN_CPU;
            resp_off   <= sel_off;
            resp_size  <= sel_size;
            resp_we    <= sel_we;
            resp_err   <= ~req_ok;
        end
    end

    // Memory read data arrives in the response cycle, so realignment is done on the fly.
    assign rd_shift = mem_rdata >> {resp_off, 3'b000};

    always_comb begin
        rd_data = 32'h0;
        if (!resp_err && !resp_we) begin
            case (resp_size)
                SZ_BYTE: rd_data = {24'h0, rd_shift[7:0]};
                SZ_HALF: rd_data = {16'h0, rd_shift[15:0]};
                default: rd_data = rd_shift;
            endcase
        end
    end

    // A response pending when reset arrives is suppressed immediately.
    assign cpu_rvalid = resp_valid & ~rst & (resp_owner == OWN_CPU);
    assign dbg_rvalid = resp_valid & ~rst & (resp_owner == OWN_DBG);
    assign cpu_err    = cpu_rvalid & resp_err;
    assign dbg_err    = dbg_rvalid & resp_err;
    assign cpu_rdata  = cpu_rvalid ? rd_data : 32'h0;
    assign dbg_rdata  = dbg_rvalid ? rd_data : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a byte-level reference memory
// and a rule-level arbitration model.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 8;
    localparam int CNT_W    = 4;

    typedef struct {
        logic        req;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic              clk;
    logic              rst;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid, cpu_err;
    logic [1:0]        cpu_size;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata, cpu_rdata;
    logic              dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid, dbg_err;
    logic [1:0]        dbg_size;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Memory device model driven by the DUT's memory port.
    logic [31:0] mem_words [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem_words[i] = 32'h0;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem_words[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= mem_words[mem_addr[7:2]];
            end
        end
    end

    // Reference: flat byte memory plus arbitration bookkeeping.
    logic [7:0] ref_mem [0:255];
    int   ref_wait   = 0;
    bit   ref_lock   = 0;
    bit   last_cpu_g = 0;
    bit   last_dbg_g = 0;
    rsp_t q_cpu [$];
    rsp_t q_dbg [$];

    initial for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;

    task automatic model_access(input req_t a, input bit port);
        int          nb;
        int          off;
        bit          ok;
        logic [31:0] val;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        rsp_t        r;
        nb  = 1 << a.size;
        off = int'(a.addr % 4);
        ok  = (a.size != 2'b11) && ((a.addr % nb) == 0);
        val = 32'h0;
        check("mem_en", mem_en, ok);
        if (ok) begin
            exp_be = 4'(((1 << nb) - 1) << off);
            check("mem_we", mem_we, a.we);
            check("mem_addr", mem_addr, a.addr & ~32'h3);
            check("mem_be", mem_be, exp_be);
            if (a.we) begin
                for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = a.wdata[8*(i % nb) +: 8];
                check("mem_wdata", mem_wdata, exp_wd);
                for (int k = 0; k < nb; k++) ref_mem[a.addr + k] = a.wdata[8*k +: 8];
            end else begin
                for (int k = 0; k < nb; k++) val[8*k +: 8] = ref_mem[a.addr + k];
            end
        end
        r.due   = cyc + 1;
        r.rdata = (ok && !a.we) ? val : 32'h0;
        r.err   = !ok;
        if (port) q_dbg.push_back(r);
        else      q_cpu.push_back(r);
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, return at posedge+1.
    task automatic step(input req_t c, input req_t d, input bit r, input bit chk_zero);
        bit exp_cpu;
        bit exp_dbg;
        cpu_req = c.req; cpu_we = c.we; cpu_size = c.size; cpu_addr = c.addr; cpu_wdata = c.wdata;
        dbg_req = d.req; dbg_we = d.we; dbg_size = d.size; dbg_addr = d.addr; dbg_wdata = d.wdata;
        dbg_lock = d.lock;
        rst = r;
        if (r) begin
            q_cpu.delete();
            q_dbg.delete();
        end
        @(negedge clk);
        if (r) begin
            check("rst cpu_gnt", cpu_gnt, 0);
            check("rst dbg_gnt", dbg_gnt, 0);
            check("rst mem_en", mem_en, 0);
            check("rst mem_we", mem_we, 0);
            check("rst mem_be", mem_be, 0);
            check("rst cpu_rvalid", cpu_rvalid, 0);
            check("rst dbg_rvalid", dbg_rvalid, 0);
            check("rst cpu_stall", cpu_stall, c.req);
            ref_wait = 0;
            ref_lock = 0;
            last_cpu_g = 0;
            last_dbg_g = 0;
        end else begin
            exp_dbg = d.req && (ref_lock || ref_wait >= MAX_WAIT || !c.req);
            exp_cpu = c.req && !exp_dbg;
            check("cpu_gnt", cpu_gnt, exp_cpu);
            check("dbg_gnt", dbg_gnt, exp_dbg);
            check("cpu_stall", cpu_stall, c.req && !exp_cpu);
            if (exp_cpu)      model_access(c, 1'b0);
            else if (exp_dbg) model_access(d, 1'b1);
            else              check("idle mem_en", mem_en, 0);
            if (exp_dbg)    ref_wait = 0;
            else if (d.req) ref_wait = (ref_wait + 1 > MAX_WAIT) ? MAX_WAIT : ref_wait + 1;
            if (exp_dbg && d.lock)     ref_lock = 1;
            else if (!d.req || !d.lock) ref_lock = 0;
            last_cpu_g = exp_cpu;
            last_dbg_g = exp_dbg;
        end
        if (chk_zero) begin
            check("zero cpu_rvalid", cpu_rvalid, 0);
            check("zero cpu_rdata", cpu_rdata, 0);
            check("zero cpu_err", cpu_err, 0);
            check("zero dbg_rdata", dbg_rdata, 0);
            check("zero mem_addr", mem_addr, 0);
            check("zero mem_wdata", mem_wdata, 0);
            check("zero mem_be", mem_be, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard whenever a response is due.
    always @(negedge clk) begin
        rsp_t e;
        if (q_cpu.size() > 0 && q_cpu[0].due == cyc) begin
            e = q_cpu.pop_front();
            check("cpu_rvalid", cpu_rvalid, 1);
            check("cpu_rdata", cpu_rdata, e.rdata);
            check("cpu_err", cpu_err, e.err);
        end else if (cpu_rvalid) begin
            check("cpu unexpected rvalid", cpu_rvalid, 0);
        end
        if (q_dbg.size() > 0 && q_dbg[0].due == cyc) begin
            e = q_dbg.pop_front();
            check("dbg_rvalid", dbg_rvalid, 1);
            check("dbg_rdata", dbg_rdata, e.rdata);
            check("dbg_err", dbg_err, e.err);
        end else if (dbg_rvalid) begin
            check("dbg unexpected rvalid", dbg_rvalid, 0);
        end
    end

    function automatic req_t mk(input bit req, input bit we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata, input bit lock);
        req_t t;
        t.req = req; t.we = we; t.size = size; t.addr = addr; t.wdata = wdata; t.lock = lock;
        return t;
    endfunction

    function automatic req_t rand_req(input int pct, input bit allow_lock);
        req_t t;
        t.req   = ($urandom_range(99) < pct);
        t.we    = $urandom_range(1);
        t.size  = 2'($urandom_range(3));
        t.addr  = 32'($urandom_range(63));
        t.wdata = $urandom;
        t.lock  = allow_lock && ($urandom_range(2) == 0);
        return t;
    endfunction

    req_t idle;
    req_t cur_c, cur_d;
    int   dbg_at;

    initial begin
        idle = mk(0, 0, 2'b00, 0, 0, 0);
        step(idle, idle, 1, 0);
        step(idle, idle, 1, 0);
        step(idle, idle, 0, 1);

        // Word store / load.
        step(mk(1, 1, 2'b10, 4, 32'h0F0F070D, 0), idle, 0, 0);
        step(mk(1, 0, 2'b10, 4, 0, 0), idle, 0, 0);
        step(idle, idle, 0, 0);

        // Byte and half store / load.
        step(mk(1, 1, 2'b00, 22, 32'h01, 0), idle, 0, 0);
        step(mk(1, 0, 2'b00, 22, 0, 0), idle, 0, 0);
        step(mk(1, 1, 2'b01, 20, 32'hFFFE, 0), idle, 0, 0);
        step(mk(1, 0, 2'b01, 20, 0, 0), idle, 0, 0);
        step(idle, idle, 0, 0);

        // Starvation: dbg forced in after MAX_WAIT denied cycles.
        dbg_at = -1;
        cur_d  = mk(1, 0, 2'b10, 8, 0, 0);
        for (int i = 0; i < 11; i++) begin
            step(mk(1, 0, 2'b10, 0, 0, 0), cur_d, 0, 0);
            if (last_dbg_g && dbg_at < 0) begin
                dbg_at = i;
                cur_d  = idle;
            end
        end
        check("starve dbg grant cycle", dbg_at, MAX_WAIT);
        step(idle, idle, 0, 0);

        // Locked debug burst holds off the CPU.
        step(idle, mk(1, 1, 2'b10, 32, 32'hA5A5_0001, 1), 0, 0);
        step(mk(1, 0, 2'b10, 32, 0, 0), mk(1, 1, 2'b10, 36, 32'hA5A5_0002, 1), 0, 0);
        step(mk(1, 0, 2'b10, 32, 0, 0), mk(1, 1, 2'b10, 40, 32'hA5A5_0003, 1), 0, 0);
        step(mk(1, 0, 2'b10, 32, 0, 0), idle, 0, 0);
        step(idle, idle, 0, 0);

        // Misaligned and invalid-size requests.
        step(mk(1, 0, 2'b01, 17, 0, 0), idle, 0, 0);
        step(mk(1, 0, 2'b10, 6, 0, 0), idle, 0, 0);
        step(mk(1, 0, 2'b11, 0, 0, 0), idle, 0, 0);
        step(idle, idle, 0, 0);

        // Reset right after a load grant drops the response.
        step(mk(1, 0, 2'b10, 4, 0, 0), idle, 0, 0);
        step(idle, idle, 1, 0);
        step(idle, idle, 0, 1);

        // Random traffic; requesters hold requests until granted.
        cur_c = idle;
        cur_d = idle;
        for (int i = 0; i < 600; i++) begin
            bit do_rst;
            if (!cur_c.req || last_cpu_g) cur_c = rand_req(70, 0);
            if (!cur_d.req || last_dbg_g) cur_d = rand_req(45, 1);
            do_rst = ($urandom_range(99) == 0);
            step(cur_c, cur_d, do_rst, 0);
        end

        for (int i = 0; i < 3; i++) step(idle, idle, 0, 0);
        check("cpu queue drained", q_cpu.size(), 0);
        check("dbg queue drained", q_dbg.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
